// File: rtl/mci.sv
//==============================================================================
// Module      : mci
// Description : Multi-cycle 32-bit MIPS-subset processor, unified memory,
//               shared datapath sequenced by a control FSM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mci_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] regfile [0:31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            regfile[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : regfile[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : regfile[i_ra2];
endmodule

module mci_mem #(
    parameter int WORDS  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);
    // Contents are deliberately not reset; they are preloaded externally.
    logic [31:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (i_we) mem[i_addr] <= i_wdata;
    end

    assign o_rdata = mem[i_addr];
endmodule

module mci #(
    parameter int MEM_WORDS = 256
) (
    input  logic clk,
    input  logic reset
);
    localparam int c_ADDR_W = $clog2(MEM_WORDS);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_LHU   = 6'h25;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SRL = 6'h02;
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTE, S_ALUWB, S_IMMEXEC, S_IMMWB, S_BRANCH, S_JUMP
    } state_t;

    state_t      r_state, w_next_state;
    logic [31:0] pc_curr, ir;
    logic [31:0] r_a, r_b, r_alu_out, r_mdr;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [31:0] w_imm_sext, w_rd1, w_rd2, w_mem_rdata;
    logic [31:0] w_alu_result, w_rf_wd;
    logic [c_ADDR_W-1:0] w_mem_addr;
    logic        w_mem_we, w_rf_we, w_funct_ok, w_take;
    logic [4:0]  w_rf_wa;

    assign w_op       = ir[31:26];
    assign w_rs       = ir[25:21];
    assign w_rt       = ir[20:16];
    assign w_rd       = ir[15:11];
    assign w_shamt    = ir[10:6];
    assign w_funct    = ir[5:0];
    assign w_imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign w_take     = (w_op == c_OP_BEQ) ? (r_a == r_b) : (r_a != r_b);
    assign w_mem_addr = (r_state == S_FETCH) ? pc_curr[c_ADDR_W+1:2]
                                             : r_alu_out[c_ADDR_W+1:2];

    mci_regfile RF (
        .clk   (clk),
        .reset (reset),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .i_we  (w_rf_we),
        .i_wa  (w_rf_wa),
        .i_wd  (w_rf_wd),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    mci_mem #(.WORDS(MEM_WORDS), .ADDR_W(c_ADDR_W)) memory (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (r_b),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_funct_ok   = 1'b0;
        w_alu_result = 32'd0;
        case (w_funct)
            c_FN_ADD: begin w_funct_ok = 1'b1; w_alu_result = r_a + r_b; end
            c_FN_SUB: begin w_funct_ok = 1'b1; w_alu_result = r_a - r_b; end
            c_FN_AND: begin w_funct_ok = 1'b1; w_alu_result = r_a & r_b; end
            c_FN_OR:  begin w_funct_ok = 1'b1; w_alu_result = r_a | r_b; end
            c_FN_SLT: begin
                w_funct_ok   = 1'b1;
                w_alu_result = {31'd0, $signed(r_a) < $signed(r_b)};
            end
            c_FN_SRL: begin w_funct_ok = 1'b1; w_alu_result = r_b >> w_shamt; end
            default:  ;
        endcase
    end

    always_comb begin
        w_next_state = S_FETCH;
        w_mem_we     = 1'b0;
        w_rf_we      = 1'b0;
        w_rf_wa      = w_rt;
        w_rf_wd      = r_alu_out;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    c_OP_RTYPE: w_next_state = w_funct_ok ? S_EXECUTE : S_FETCH;
                    c_OP_LW, c_OP_LHU, c_OP_SW: w_next_state = S_MEMADR;
                    c_OP_BEQ, c_OP_BNE:         w_next_state = S_BRANCH;
                    c_OP_J, c_OP_JAL:           w_next_state = S_JUMP;
                    c_OP_SLTIU:                 w_next_state = S_IMMEXEC;
                    default:                    w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (w_op == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB: begin
                w_rf_we = 1'b1;
                // Halfword lane chosen by byte-address bit 1.
                w_rf_wd = (w_op == c_OP_LW) ? r_mdr :
                          {16'd0, r_alu_out[1] ? r_mdr[31:16] : r_mdr[15:0]};
            end
            S_MEMWRITE: w_mem_we = 1'b1;
            S_EXECUTE:  w_next_state = S_ALUWB;
            S_ALUWB: begin
                w_rf_we = 1'b1;
                w_rf_wa = w_rd;
            end
            S_IMMEXEC:  w_next_state = S_IMMWB;
            S_IMMWB:    w_rf_we = 1'b1;
            S_JUMP: begin
                w_rf_we = (w_op == c_OP_JAL);
                w_rf_wa = 5'd31;
                w_rf_wd = pc_curr;
            end
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            pc_curr   <= '0;
            ir        <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_FETCH: begin
                    ir      <= w_mem_rdata;
                    pc_curr <= pc_curr + 32'd4;
                end
                S_DECODE: begin
                    r_a       <= w_rd1;
                    r_b       <= w_rd2;
                    r_alu_out <= pc_curr + (w_imm_sext << 2);
                end
                S_MEMADR:  r_alu_out <= r_a + w_imm_sext;
                S_MEMREAD: r_mdr <= w_mem_rdata;
                S_EXECUTE: r_alu_out <= w_alu_result;
                S_IMMEXEC: r_alu_out <= {31'd0, r_a < w_imm_sext};
                S_BRANCH:  if (w_take) pc_curr <= r_alu_out;
                S_JUMP:    pc_curr <= {pc_curr[31:28], ir[25:0], 2'b00};
                default:   ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mci.sv
//==============================================================================
// Module      : tb_mci
// Description : Directed program bench for the mci processor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mci;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mci #(.MEM_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) dut.memory.mem[i] = 32'd0;
        dut.memory.mem[0]  = r_ins(9, 10, 11, 0, 6'h22);          // SUB $t3
        dut.memory.mem[1]  = r_ins(9, 10, 11, 0, 6'h24);          // AND $t3
        dut.memory.mem[2]  = r_ins(9, 10, 11, 0, 6'h25);          // OR  $t3
        dut.memory.mem[3]  = r_ins(10, 9, 11, 0, 6'h2A);          // SLT $t3,$t2,$t1
        dut.memory.mem[4]  = j_ins(6'h03, 26'h20);                // JAL 0x80
        dut.memory.mem[5]  = i_ins(6'h25, 28, 11, 16'd10);        // LHU upper
        dut.memory.mem[6]  = i_ins(6'h25, 28, 11, 16'd8);         // LHU lower
        dut.memory.mem[7]  = i_ins(6'h2B, 28, 9, 16'd12);         // SW to be aborted
        dut.memory.mem[32] = r_ins(0, 9, 11, 1, 6'h02);           // SRL $t3,$t1,1
        dut.memory.mem[33] = r_ins(9, 10, 8, 0, 6'h20);           // ADD $t0
        dut.memory.mem[34] = r_ins(9, 10, 0, 0, 6'h20);           // ADD $zero
        dut.memory.mem[35] = i_ins(6'h2B, 28, 8, 16'd8);          // SW $t0,8($gp)
        dut.memory.mem[36] = i_ins(6'h23, 28, 11, 16'd8);         // LW $t3,8($gp)
        dut.memory.mem[37] = i_ins(6'h0B, 10, 8, 16'hFFFF);       // SLTIU $t0,$t2,-1
        dut.memory.mem[38] = i_ins(6'h04, 9, 9, 16'd2);           // BEQ taken
        dut.memory.mem[39] = r_ins(0, 0, 11, 0, 6'h20);           // skipped
        dut.memory.mem[40] = r_ins(0, 0, 11, 0, 6'h20);           // skipped
        dut.memory.mem[41] = i_ins(6'h05, 9, 9, 16'd2);           // BNE not taken
        dut.memory.mem[42] = 32'hFC00_0000;                       // unknown opcode
        dut.memory.mem[43] = r_ins(9, 10, 11, 0, 6'h3F);          // unknown funct
        dut.memory.mem[44] = j_ins(6'h02, 26'h5);                 // J 0x14
        dut.memory.mem[67] = 32'hDEAD_BEEF;

        #12;
        check("reset_pc", dut.pc_curr, 32'h0);
        check("reset_ir", dut.ir, 32'h0);
        #8;
        reset = 1'b1;
        dut.RF.regfile[9]  = 32'd7;
        dut.RF.regfile[10] = 32'd3;
        dut.RF.regfile[28] = 32'h100;
        #1;
        check("pc_before_fetch", dut.pc_curr, 32'h0);

        cyc(1);
        check("first_fetch_pc", dut.pc_curr, 32'h4);
        check("first_fetch_ir", dut.ir, r_ins(9, 10, 11, 0, 6'h22));
        cyc(3);
        check("sub", dut.RF.regfile[11], 32'd4);
        cyc(4);
        check("and", dut.RF.regfile[11], 32'd3);
        check("and_pc", dut.pc_curr, 32'h8);
        cyc(4);
        check("or", dut.RF.regfile[11], 32'd7);
        cyc(4);
        check("slt", dut.RF.regfile[11], 32'd1);
        check("slt_pc", dut.pc_curr, 32'h10);
        cyc(3);
        check("jal_pc", dut.pc_curr, 32'h80);
        check("jal_ra", dut.RF.regfile[31], 32'h14);
        cyc(4);
        check("srl", dut.RF.regfile[11], 32'd3);
        cyc(4);
        check("add", dut.RF.regfile[8], 32'h0000_000A);
        cyc(4);
        check("add_zero", dut.RF.regfile[0], 32'd0);
        check("add_zero_pc", dut.pc_curr, 32'h8C);
        cyc(4);
        check("sw_mem", dut.memory.mem[66], 32'h0000_000A);
        check("sw_pc", dut.pc_curr, 32'h90);
        cyc(4);
        check("lw_not_early", dut.RF.regfile[11], 32'd3);
        cyc(1);
        check("lw", dut.RF.regfile[11], 32'h0000_000A);
        check("lw_pc", dut.pc_curr, 32'h94);
        dut.memory.mem[66] = 32'h1234_5678;
        cyc(4);
        check("sltiu", dut.RF.regfile[8], 32'd1);
        cyc(3);
        check("beq_taken_pc", dut.pc_curr, 32'hA4);
        cyc(3);
        check("bne_fall_pc", dut.pc_curr, 32'hA8);
        cyc(2);
        check("unk_op_pc", dut.pc_curr, 32'hAC);
        cyc(2);
        check("unk_fn_pc", dut.pc_curr, 32'hB0);
        check("unk_fn_rd", dut.RF.regfile[11], 32'h0000_000A);
        cyc(3);
        check("j_pc", dut.pc_curr, 32'h14);
        cyc(5);
        check("lhu_hi", dut.RF.regfile[11], 32'h0000_1234);
        cyc(5);
        check("lhu_lo", dut.RF.regfile[11], 32'h0000_5678);
        check("lhu_pc", dut.pc_curr, 32'h1C);

        // Two edges into the SW puts the FSM in its address-calculation state.
        cyc(2);
        check("sw_abort_pc_pre", dut.pc_curr, 32'h20);
        reset = 1'b0;
        #1;
        check("abort_pc", dut.pc_curr, 32'h0);
        check("abort_ir", dut.ir, 32'h0);
        check("abort_rf", dut.RF.regfile[9], 32'h0);
        cyc(2);
        check("abort_mem", dut.memory.mem[67], 32'hDEAD_BEEF);
        check("abort_pc_hold", dut.pc_curr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/mci.md
# mci

Multi-cycle 32-bit MIPS-subset processor with a single unified instruction/data memory. Each instruction runs through a shared-datapath control FSM: fetch, decode, then execute, memory and writeback as needed. Memory and register file are internal and preloaded or inspected by hierarchical reference. The only ports are clock and reset.

## Interface
- MEM_WORDS, 256, unified memory depth in 32-bit words (1 KiB byte space).
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clock clk.
- Hierarchical names the bench depends on (mandatory):
  - `pc_curr` (32-bit PC).
  - `ir` (32-bit instruction register).
  - instance `RF` with array `regfile[0:31]`.
  - instance `memory` with array `mem[0:MEM_WORDS-1]`, word index = byte address[9:2].

## Operation
- Supported instructions, MIPS encodings:
  - R-type (op 0x00), selected by funct:
    - ADD 0x20, SUB 0x22, AND 0x24, OR 0x25: rd = rs op rt.
    - SLT 0x2A: signed compare.
    - SRL 0x02: rd = rt >> shamt, logical.
  - LW 0x23: rt = mem[rs+sext(imm)].
  - SW 0x2B: mem[rs+sext(imm)] = rt.
  - LHU 0x25: rt = zero-extended halfword; byte address bit 1 = 0 selects word[15:0], bit 1 = 1 selects word[31:16].
  - BEQ 0x04, BNE 0x05: target = PC+4 + (sext(imm)<<2).
  - J 0x02: PC = {PC+4[31:28], target, 2'b00}.
  - JAL 0x03: same as J, and $31 = PC+4.
  - SLTIU 0x0B: rt = (rs < sext(imm)), unsigned compare, result 0 or 1.
- Arithmetic is 32-bit wraparound. There are no overflow exceptions.
- Register 0 reads as 0; writes to it are discarded.
- Memory addresses ignore bits [1:0] for word access and bits above [9].
- Unknown opcode or funct: no architectural effect. The FSM returns to FETCH after DECODE and PC has already advanced by 4.
- FSM states:
  - FETCH: IR = mem[PC]; PC = PC+4.
  - DECODE: read A=rs, B=rt; ALUOut = PC + (sext(imm)<<2).
  - MEMADR: ALUOut = A + sext(imm). Next state is MEMREAD (LW/LHU) or MEMWRITE (SW).
  - MEMREAD: MDR = mem[ALUOut].
  - MEMWB: writes rt.
  - MEMWRITE: stores B, then FETCH.
  - EXECUTE: R-type ALU op.
  - ALUWB: writes rd, then FETCH.
  - IMMEXEC: SLTIU compare.
  - IMMWB: writes rt, then FETCH.
  - BRANCH: PC = ALUOut if the condition holds, then FETCH.
  - JUMP: sets PC; JAL also writes $31. Then FETCH.

## Timing
- Cycles per instruction:
  - 3: BEQ, BNE, J, JAL.
  - 4: R-type, SW, SLTIU.
  - 5: LW, LHU.
  - 2: unknown opcode.
- While reset is low: PC=0, IR=0, state=FETCH, all 32 registers = 0, internal A/B/ALUOut/MDR = 0. Memory contents are not cleared.
- First fetch happens on the first rising edge after reset deasserts.
- Reset asserted mid-instruction aborts it immediately. No pending register or memory write completes afterwards.
- Register-file and memory writes are synchronous. A value written in cycle N is readable in cycle N+1.
- A back-to-back dependent instruction always sees the prior result; the multi-cycle sequencing guarantees this with no forwarding.

## Test plan
- Reset and preload: reset low 20 ns, then preload $t1=7, $t2=3, $gp=0x100.
  - During reset: pc_curr=0, ir=0.
  - After reset: PC steps 0→4 after the first FETCH.
- ALU: ADD $t0,$t1,$t2 → $t0=0x0000000A. SUB → 4. AND → 3. OR → 7. SLT $t3,$t2,$t1 → 1. SRL $t3,$t1,1 → 3.
  - Each of these takes exactly 4 cycles.
- Memory: SW $t0,8($gp) → mem[66] (byte 0x108) = 0x0000000A. LW $t3,8($gp) → $t3=0x0000000A.
  - With mem[66]=0x12345678: LHU offset 10 → 0x00001234; LHU offset 8 → 0x00005678.
- Branch: BEQ $t1,$t1,+2 → PC skips two instructions. BNE $t1,$t1,+2 → falls through.
  - Check both directions and the 3-cycle latency.
- Jumps: JAL to word 0x20 from PC 0x10 → PC=0x80, $31=0x14. J back works. SLTIU $t0,$t2,-1 → 1, since 0xFFFFFFFF is unsigned max.
- Edge cases:
  - ADD $zero,$t1,$t2 leaves $zero = 0.
  - Reset pulsed during a SW's MEMADR cycle: no memory write, and PC returns to 0.
